// File: rtl/maybe_word_packer_if.sv
// Bundle of the Maybe byte stream input, downstream ready, and the packed-word outputs.
// The master drives the stream and ready; the slave (the packer) returns word, gap and overflow.
interface maybe_word_packer_if;
    logic        __in0;
    logic [7:0]  __in1;
    logic        __in2;
    logic        __out0;
    logic [15:0] __out1;
    logic [7:0]  __out2;
    logic        __out3;

    modport master (
        output __in0, __in1, __in2,
        input  __out0, __out1, __out2, __out3
    );

    modport slave (
        input  __in0, __in1, __in2,
        output __out0, __out1, __out2, __out3
    );
endinterface

// File: rtl/maybe_word_packer.sv
// Packs pairs of Just bytes big-endian into 16-bit words, queued in a 4-deep FIFO,
// and tracks the current Nothing run length plus a sticky dropped-word flag.
module maybe_word_packer (
    input  logic                 clk,
    input  logic                 rst,
    maybe_word_packer_if.slave   bus
);
    localparam int DEPTH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    pack_state_t state;
    logic [7:0]  hi;
    logic [15:0] mem [DEPTH];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;
    logic [7:0]  gap;
    logic        ovf;

    logic        pop;
    logic        push;
    logic        full;
    logic        accept;
    logic        drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [2:0] next_count(input logic [2:0] c, input logic in, input logic out);
        return c + {2'b00, in} - {2'b00, out};
    endfunction

    // A full FIFO still takes the new word when the head leaves on the same edge.
    always_comb begin
        pop    = (count != 3'd0) && bus.__in2;
        push   = bus.__in0 && (state == HALF);
        full   = (count == 3'(DEPTH));
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
            gap    <= 8'h00;
            ovf    <= 1'b0;
        end else begin
            if (bus.__in0) begin
                state <= (state == EMPTY) ? HALF : EMPTY;
                gap   <= 8'h00;
            end else begin
                gap   <= sat_inc(gap);
            end
            if (accept)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= next_count(count, accept, pop);
            if (drop)
                ovf <= 1'b1;
        end
    end

    // Data path: pending high byte and FIFO storage carry no reset.
    always_ff @(posedge clk) begin
        if (bus.__in0 && state == EMPTY)
            hi <= bus.__in1;
        if (accept && !rst)
            mem[wr_ptr] <= {hi, bus.__in1};
    end

    assign bus.__out0 = (count != 3'd0);
    assign bus.__out1 = (count != 3'd0) ? mem[rd_ptr] : 16'h0000;
    assign bus.__out2 = gap;
    assign bus.__out3 = ovf;
endmodule

// File: tb/tb_maybe_word_packer.sv
// Self-checking bench for maybe_word_packer: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_maybe_word_packer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    maybe_word_packer_if bus ();

    maybe_word_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [15:0] mq [$];
    bit          m_pend;
    logic [7:0]  m_hi;
    logic [7:0]  m_gap;
    bit          m_ovf;

    task automatic step(input logic f, input logic [7:0] b, input logic r, input logic rs);
        bit popd;
        bus.__in0 = f;
        bus.__in1 = b;
        bus.__in2 = r;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_pend = 0;
            m_gap  = 8'h00;
            m_ovf  = 0;
        end else begin
            popd = (mq.size() != 0) && r;
            if (popd) void'(mq.pop_front());
            if (f) begin
                if (m_pend) begin
                    if (mq.size() < 4) mq.push_back({m_hi, b});
                    else m_ovf = 1;
                    m_pend = 0;
                end else begin
                    m_hi   = b;
                    m_pend = 1;
                end
                m_gap = 8'h00;
            end else begin
                m_gap = (m_gap == 8'hFF) ? 8'hFF : m_gap + 8'd1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 8'h77, 1'b1, 1'b1);
        n_cmp++;
        if ({bus.__out0, bus.__out1, bus.__out2, bus.__out3} !== 26'h0) begin
            n_bad++;
            $display("FAIL reset_values got=%h want=%h",
                     {bus.__out0, bus.__out1, bus.__out2, bus.__out3}, 26'h0);
        end
    endtask

    task automatic test_basic_pair();
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        step(1'b1, 8'hCD, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.__out0, bus.__out1} !== {1'b1, 16'hABCD}) begin
            n_bad++;
            $display("FAIL basic_word got=%h want=%h", {bus.__out0, bus.__out1}, {1'b1, 16'hABCD});
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (bus.__out0 !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_popped got=%b want=0", bus.__out0);
        end
    endtask

    task automatic test_gap();
        step(1'b1, 8'h12, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 8'hFF, 1'b0, 1'b0);
            n_cmp++;
            if (bus.__out2 !== 8'(i)) begin
                n_bad++;
                $display("FAIL gap_count got=%0d want=%0d", bus.__out2, i);
            end
        end
        step(1'b1, 8'h34, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.__out0, bus.__out1, bus.__out2} !== {1'b1, 16'h1234, 8'h00}) begin
            n_bad++;
            $display("FAIL gap_word got=%h want=%h",
                     {bus.__out0, bus.__out1, bus.__out2}, {1'b1, 16'h1234, 8'h00});
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        n_cmp++;
        if (bus.__out3 !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got=%b want=1", bus.__out3);
        end
        for (int k = 0; k < 4; k++) begin
            exp = {8'(2 * k + 1), 8'(2 * k + 2)};
            n_cmp++;
            if ({bus.__out0, bus.__out1, bus.__out3} !== {1'b1, exp, 1'b1}) begin
                n_bad++;
                $display("FAIL ovf_drain%0d got=%h want=%h", k,
                         {bus.__out0, bus.__out1, bus.__out3}, {1'b1, exp, 1'b1});
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if ({bus.__out0, bus.__out1, bus.__out3} !== {1'b0, 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_empty got=%h want=%h",
                     {bus.__out0, bus.__out1, bus.__out3}, {1'b0, 16'h0000, 1'b1});
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_words [5];
        exp_words = '{16'h2122, 16'h2324, 16'h2526, 16'h2728, 16'h292A};
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        step(1'b1, 8'h2A, 1'b1, 1'b0);
        n_cmp++;
        if (bus.__out3 !== 1'b0) begin
            n_bad++;
            $display("FAIL fullpp_ovf got=%b want=0", bus.__out3);
        end
        for (int k = 1; k < 5; k++) begin
            n_cmp++;
            if ({bus.__out0, bus.__out1} !== {1'b1, exp_words[k]}) begin
                n_bad++;
                $display("FAIL fullpp_order%0d got=%h want=%h", k,
                         {bus.__out0, bus.__out1}, {1'b1, exp_words[k]});
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (bus.__out0 !== 1'b0) begin
            n_bad++;
            $display("FAIL fullpp_empty got=%b want=0", bus.__out0);
        end
    endtask

    task automatic test_saturate();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (i == 254 || i == 255 || i == 300) begin
                n_cmp++;
                if (bus.__out2 !== ((i >= 255) ? 8'hFF : 8'(i))) begin
                    n_bad++;
                    $display("FAIL gap_sat@%0d got=%h want=%h", i, bus.__out2,
                             (i >= 255) ? 8'hFF : 8'(i));
                end
            end
        end
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        n_cmp++;
        if (bus.__out2 !== 8'h00) begin
            n_bad++;
            $display("FAIL gap_clear got=%h want=00", bus.__out2);
        end
    endtask

    task automatic test_reset_mid_pair();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        n_cmp++;
        if ({bus.__out0, bus.__out1, bus.__out2, bus.__out3} !== 26'h0) begin
            n_bad++;
            $display("FAIL midrst_values got=%h want=%h",
                     {bus.__out0, bus.__out1, bus.__out2, bus.__out3}, 26'h0);
        end
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.__out0, bus.__out1} !== {1'b1, 16'h1122}) begin
            n_bad++;
            $display("FAIL midrst_word got=%h want=%h", {bus.__out0, bus.__out1}, {1'b1, 16'h1122});
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (bus.__out0 !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_single got=%b want=0", bus.__out0);
        end
    endtask

    task automatic test_random();
        logic [25:0] exp;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 149) == 0);
            exp = {mq.size() != 0, (mq.size() != 0) ? mq[0] : 16'h0000, m_gap, m_ovf};
            n_cmp++;
            if ({bus.__out0, bus.__out1, bus.__out2, bus.__out3} !== exp) begin
                n_bad++;
                $display("FAIL random@%0d got=%h want=%h", i,
                         {bus.__out0, bus.__out1, bus.__out2, bus.__out3}, exp);
            end
        end
    endtask

    initial begin
        bus.__in0 = 1'b0;
        bus.__in1 = 8'h00;
        bus.__in2 = 1'b0;
        m_pend = 0;
        m_hi   = 8'h00;
        m_gap  = 8'h00;
        m_ovf  = 0;
        test_reset();
        test_basic_pair();
        test_gap();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_reset_mid_pair();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/maybe_word_packer.md
# maybe_word_packer

Consumer end of the Maybe-encoded byte stream produced by our ReWire `top_level` blocks: each cycle carries a Just/Nothing flag plus an 8-bit payload. The block takes Just bytes in pairs, packs each pair big-endian into a 16-bit word, and buffers words in a 4-entry FIFO drained by a ready handshake. It also reports the current run length of Nothing cycles and a sticky overflow flag. It sits directly downstream of any block emitting `{flag, byte}` on its first two outputs.

## Interface
- No parameters; FIFO depth fixed at 4, word width fixed at 16.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- __in0  input  1  Maybe flag: 1 = Just (payload valid), 0 = Nothing.
- __in1  input  8  payload byte; ignored when __in0 = 0.
- __in2  input  1  downstream ready; a word is consumed on a cycle with __out0 = 1 and __in2 = 1.
- __out0  output  1  word valid (FIFO non-empty).
- __out1  output  16  FIFO head word; 16'h0000 when __out0 = 0.
- __out2  output  8  Nothing run counter, saturating at 8'hFF.
- __out3  output  1  sticky overflow: a completed word was dropped.

## Operation
- State: pending flag `pend` plus 8-bit high byte `hi`; FIFO of 4×16 with 2-bit read/write pointers and a 3-bit count; 8-bit gap counter; overflow bit.
- Packer states: EMPTY (pend = 0) and HALF (pend = 1).
  - EMPTY, Just b: hi <= b, go to HALF; no push.
  - HALF, Just b: push {hi, b}; go to EMPTY.
  - Nothing in either state: no state change; pending byte held indefinitely, with no timeout and no flush.
- Push/pop on the same edge:
  - pop = __out0 & __in2
  - push = completed word
  - count_next = count + push_accepted − pop
- Full (count = 4):
  - With push and pop in the same cycle, the push is accepted; count stays 4.
  - With push and no pop, the word is dropped, __out3 <= 1, and FIFO contents are unchanged.
- Empty: __in2 is ignored and pointers do not move.
- Pointers wrap modulo 4.
- Gap counter:
  - Nothing cycle: counter <= min(counter + 1, 255).
  - Just cycle: counter <= 0.
  - A Nothing run after saturation holds 255.
- __out3 clears only on rst.
- rst overrides all inputs in the same cycle: in-flight half byte, FIFO contents and the current handshake are all discarded.

## Timing
- All outputs are driven from registers or from the FIFO head register/array; there is no combinational input→output path except through clk.
- Reset values: __out0 = 0, __out1 = 16'h0000, __out2 = 8'h00, __out3 = 0, pend = 0, pointers and count = 0.
- Latency: a word whose second byte arrives in cycle N is visible on __out0/__out1 in cycle N+1 when the FIFO was empty; words are otherwise presented in FIFO order.
- Throughput: one word per 2 Just cycles at most. With __in2 held high, the FIFO never exceeds 1 entry.
- Pop takes effect at the edge: the next head appears in the following cycle, or __out0 drops to 0.
- The gap counter update is visible the cycle after the sampled input.
- rst asserted in cycle N gives reset values in cycle N+1, regardless of other inputs.

## Test plan
- Reset, then Just 8'hAB, Just 8'hCD with __in2 = 1: one cycle later __out0 = 1, __out1 = 16'hABCD; the following cycle __out0 = 0.
- Just 8'h12, Nothing ×3, Just 8'h34: __out2 reads 1, 2, 3 during the gap, then 0. The word 16'h1234 is produced even though the gap separated its bytes.
- __in2 = 0 with 10 Just bytes 8'h01..8'h0A:
  - FIFO holds 16'h0102, 16'h0304, 16'h0506, 16'h0708.
  - 16'h090A is dropped and __out3 = 1.
  - Then __in2 = 1 drains exactly the 4 words in order, and __out3 stays 1.
- FIFO full with __in2 = 1 while the 2nd byte of a pair arrives: the pop and push are both accepted, count stays 4, __out3 stays 0, and the new word appears 4th in order.
- 300 consecutive Nothing cycles: __out2 saturates at 8'hFF and holds; one Just then returns __out2 to 0.
- rst mid-pair (after Just 8'hEE) with 2 words queued:
  - Next cycle all outputs are at reset values.
  - Then Just 8'h11, Just 8'h22 yields 16'h1122, which shows the half byte 8'hEE was discarded.
